led_stream_decoder: RTL and testbench
=====================================

# led_stream_decoder

Receive-side counterpart of the LED strip bit driver: decodes a WS2812-style single-wire NRZ pulse stream back into 24-bit pixel words. It classifies each high pulse by width, assembles bits MSB-first into pixels, and reports pixel index, frame boundaries and protocol errors. It sits on a loopback or daisy-chain input pin and feeds the frame checker and on-board test logic, so driver output can be verified in hardware.

## Interface
Parameters:
- `MAX_PIXELS`, default 144: pixels accepted per frame; later pixels are dropped.
- `T_MIN_HIGH`, default 5: minimum legal high width in clk cycles; shorter is a glitch error.
- `T_THRESH`, default 29: high width `>= T_THRESH` decodes as 1, otherwise 0.
- `T_MAX_HIGH`, default 60: high width `> T_MAX_HIGH` is an error.
- `T_RESET`, default 2400: low width `>= T_RESET` is a latch/reset gap (50 µs at 48 MHz).

Ports:
- `clk` in 1: system clock, 48 MHz nominal.
- `rst_n` in 1: asynchronous, active-low reset.
- `din` in 1: asynchronous serial LED data input.
- `pixel` out 24: last completed pixel, first received bit in [23].
- `pixel_valid` out 1: one-cycle strobe; `pixel` and `pixel_idx` are valid.
- `pixel_idx` out 8: index of `pixel` within the current frame, 0-based.
- `frame_done` out 1: one-cycle strobe on a latch gap that ends a non-empty frame.
- `pixel_count` out 8: complete pixels in the last finished frame; updated with `frame_done`.
- `bit_error` out 1: one-cycle strobe on any protocol violation.
- `overflow` out 1: set when a pixel beyond `MAX_PIXELS` arrives; cleared on the next `frame_done`.

## Operation
- `din` passes through a 2-flop synchronizer to give `din_s`. All decoding uses `din_s`.
- `high_cnt` and `low_cnt` are 16-bit counters that saturate at 0xFFFF.
- `bit_cnt` (0..23) counts bits within the current pixel. `idx` counts pixels within the current frame.
- SYNC (state after reset and after any error):
  - Counts consecutive low cycles and ignores all data.
  - When `low_cnt` reaches `T_RESET`, clears `bit_cnt` and `idx`, then moves to WAIT_HIGH. No `frame_done` is issued.
  - Any high cycle before that point clears `low_cnt`.
- WAIT_HIGH:
  - Counts low cycles.
  - When `din_s` goes 1: `high_cnt` is loaded to 1 and the state moves to HIGH.
  - When `low_cnt` reaches `T_RESET`: the latch event occurs (see below). State stays WAIT_HIGH and `low_cnt` holds, so only one event fires per gap.
- HIGH:
  - Increments `high_cnt` each cycle `din_s` = 1.
  - If `high_cnt` exceeds `T_MAX_HIGH`, pulse `bit_error` and go to SYNC.
  - On the first cycle with `din_s` = 0:
    - If `high_cnt < T_MIN_HIGH`, pulse `bit_error` and go to SYNC.
    - Otherwise shift the bit `(high_cnt >= T_THRESH)` into the shift register LSB, increment `bit_cnt`, load `low_cnt` to 1, and go to WAIT_HIGH.
- Pixel completion (24th bit):
  - Transfer the shift register to `pixel`, pulse `pixel_valid` with `pixel_idx = idx`, increment `idx`, and reset `bit_cnt` to 0.
  - If `idx >= MAX_PIXELS`, suppress `pixel_valid`, set `overflow`, and leave `idx` saturated.
- Latch event:
  - If `idx > 0` or `bit_cnt > 0`: pulse `frame_done` and set `pixel_count = min(idx, MAX_PIXELS)`.
  - If `bit_cnt != 0` at the latch, also pulse `bit_error` in the same cycle; the partial pixel is discarded.
  - Clear `idx`, `bit_cnt` and `overflow`.
  - An empty gap produces no strobe.
- Errors never emit a partial pixel. Pixels completed before an error keep their `pixel_valid`. The error-terminated frame gets no `frame_done`.

## Timing
- Reset state: all outputs are 0, state is SYNC, all counters are 0. Reset asserted mid-frame aborts immediately and loses the partial frame.
- Latency from a `din` falling edge to the bit being registered is 3 clk cycles (2 synchronizer + 1 classify).
- `pixel_valid` asserts in the cycle after the 24th bit is registered, i.e. 4 cycles after the 24th falling edge.
- `frame_done` asserts on the cycle `low_cnt` equals `T_RESET`, counted from the first synchronized low cycle.
- `pixel`, `pixel_idx` and `pixel_count` are registered and hold until next updated.
- The strobes are single-cycle. `pixel_valid` and `frame_done` never coincide, because a latch requires `T_RESET` low cycles after the last bit.
- Inter-bit low gaps of any length below `T_RESET` are legal. Decoding is independent of bit period.

## Test plan
- Reset with `din` low, hold 2400 cycles, send bits (38 high / 22 low = 1, 19 high / 41 low = 0) forming 0xFF0000, 0x00FF00, 0x0000A5, then 2400 low:
  - Expect `pixel_valid` ×3 with `pixel_idx` 0, 1, 2 and the exact words.
  - Expect one `frame_done` with `pixel_count` = 3 and no `bit_error`.
- Threshold edges: high widths 28, 29, 5 and 60 decode as 0, 1, 0, 1. Widths 4 and 61 pulse `bit_error`, output no pixel, and need a 2400-cycle gap before the next pixel decodes.
- 10 bits, then a 2400-cycle gap:
  - Expect `frame_done` and `bit_error` in the same cycle, `pixel_count` = 0, no `pixel_valid`.
  - A following full pixel decodes at `pixel_idx` 0.
- With `MAX_PIXELS` = 144, send 146 pixels: 144 `pixel_valid` (idx 0..143), `overflow` = 1, `frame_done` with `pixel_count` = 144, then `overflow` = 0.
- Deassert `rst_n` at bit 12 of pixel 5: outputs are 0 immediately. After release, data arriving without a preceding 2400-cycle low gap is ignored.
- Two consecutive 2400-cycle gaps after one frame: exactly one `frame_done`.

Source files
------------

// File: rtl/led_stream_if.sv
// Signal bundle between the LED stream decoder and its consumers.
// The decoder takes the master view: it samples din and drives the results.
interface led_stream_if;
    logic        din;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [7:0]  pixel_idx;
    logic        frame_done;
    logic [7:0]  pixel_count;
    logic        bit_error;
    logic        overflow;

    modport master (
        input  din,
        output pixel, pixel_valid, pixel_idx, frame_done, pixel_count, bit_error, overflow
    );

    modport slave (
        output din,
        input  pixel, pixel_valid, pixel_idx, frame_done, pixel_count, bit_error, overflow
    );
endinterface

// File: rtl/led_stream_decoder.sv
// Decodes a WS2812-style NRZ pulse stream into 24-bit pixels (MSB first),
// with pixel index, frame-latch detection and protocol error reporting.
module led_stream_decoder #(
    parameter int unsigned MAX_PIXELS = 144,
    parameter int unsigned T_MIN_HIGH = 5,
    parameter int unsigned T_THRESH   = 29,
    parameter int unsigned T_MAX_HIGH = 60,
    parameter int unsigned T_RESET    = 2400
) (
    input  logic          clk,
    input  logic          rst_n,
    led_stream_if.master  bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned PIX_W = 24;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned BIT_W = 5;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {SYNC, WAIT_HIGH, HIGH} state_t;

    state_t           state_q, state_d;
    logic             din_meta, din_s;
    logic [CNT_W-1:0] high_q, high_d, low_q, low_d, high_inc, low_inc;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PIX_W-1:0] shreg_q, shreg_d;
    logic             pend_q, pend_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic             pv_q, pv_d;
    logic [IDX_W-1:0] pidx_q, pidx_d;
    logic             fd_q, fd_d;
    logic [IDX_W-1:0] pcnt_q, pcnt_d;
    logic             be_q, be_d;
    logic             ovf_q, ovf_d;

    // Two-flop synchronizer for the asynchronous data pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
        end else begin
            din_meta <= bus.din;
            din_s    <= din_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SYNC;
            high_q  <= '0;
            low_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            pend_q  <= 1'b0;
            pixel_q <= '0;
            pv_q    <= 1'b0;
            pidx_q  <= '0;
            fd_q    <= 1'b0;
            pcnt_q  <= '0;
            be_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            high_q  <= high_d;
            low_q   <= low_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            pend_q  <= pend_d;
            pixel_q <= pixel_d;
            pv_q    <= pv_d;
            pidx_q  <= pidx_d;
            fd_q    <= fd_d;
            pcnt_q  <= pcnt_d;
            be_q    <= be_d;
            ovf_q   <= ovf_d;
        end
    end

    assign high_inc = (high_q == CNT_SAT) ? high_q : high_q + CNT_W'(1);
    assign low_inc  = (low_q == CNT_SAT) ? low_q : low_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        high_d  = high_q;
        low_d   = low_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pend_d  = 1'b0;
        pixel_d = pixel_q;
        pv_d    = 1'b0;
        pidx_d  = pidx_q;
        fd_d    = 1'b0;
        pcnt_d  = pcnt_q;
        be_d    = 1'b0;
        ovf_d   = ovf_q;

        unique case (state_q)
            SYNC: begin
                if (din_s) begin
                    low_d = '0;
                end else begin
                    low_d = low_inc;
                    if (low_inc == CNT_W'(T_RESET)) begin
                        bit_d   = '0;
                        idx_d   = '0;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (din_s) begin
                    high_d  = CNT_W'(1);
                    state_d = HIGH;
                end else if (low_q < CNT_W'(T_RESET)) begin
                    // low_cnt stops at T_RESET so a long gap latches once
                    low_d = low_inc;
                    if (low_inc == CNT_W'(T_RESET)) begin
                        if ((idx_q != '0) || (bit_q != '0)) begin
                            fd_d   = 1'b1;
                            pcnt_d = idx_q;
                            be_d   = (bit_q != '0);
                        end
                        idx_d = '0;
                        bit_d = '0;
                        ovf_d = 1'b0;
                    end
                end
            end
            HIGH: begin
                if (din_s) begin
                    high_d = high_inc;
                    if (high_inc > CNT_W'(T_MAX_HIGH)) begin
                        be_d    = 1'b1;
                        low_d   = '0;
                        state_d = SYNC;
                    end
                end else if (high_q < CNT_W'(T_MIN_HIGH)) begin
                    be_d    = 1'b1;
                    low_d   = CNT_W'(1);
                    state_d = SYNC;
                end else begin
                    shreg_d = {shreg_q[PIX_W-2:0], (high_q >= CNT_W'(T_THRESH))};
                    low_d   = CNT_W'(1);
                    state_d = WAIT_HIGH;
                    if (bit_q == BIT_W'(PIX_W - 1)) begin
                        bit_d  = '0;
                        pend_d = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = SYNC;
        endcase

        // Publish a completed pixel the cycle after its last bit lands
        if (pend_q) begin
            if (idx_q < IDX_W'(MAX_PIXELS)) begin
                pixel_d = shreg_q;
                pv_d    = 1'b1;
                pidx_d  = idx_q;
                idx_d   = idx_q + IDX_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign bus.pixel       = pixel_q;
    assign bus.pixel_valid = pv_q;
    assign bus.pixel_idx   = pidx_q;
    assign bus.frame_done  = fd_q;
    assign bus.pixel_count = pcnt_q;
    assign bus.bit_error   = be_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_led_stream_decoder.sv
// Directed bench for led_stream_decoder: drives pulse trains and checks
// pixels/frames against queues of expected results.
module tb_led_stream_decoder;
    logic clk;
    logic rst_n;
    led_stream_if bus ();

    led_stream_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [23:0] w; logic [7:0] i; } pix_t;
    typedef struct { logic [7:0] cnt; logic err; } frm_t;

    pix_t pix_q[$];
    frm_t frm_q[$];
    pix_t p;
    frm_t f;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_fall = 0;
    int err_events = 0;
    int frames_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input int hi, input int lo);
        bus.din = 1'b1;
        repeat (hi) @(negedge clk);
        bus.din = 1'b0;
        last_fall = cyc;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_pixel(input logic [23:0] w, input int one_hi, input int zero_hi, input int lo);
        for (int b = 23; b >= 0; b--)
            send_bit(w[b] ? one_hi : zero_hi, lo);
    endtask

    // Standard-timing pixel: 38/22 for a one, 19/41 for a zero
    task automatic std_pixel(input logic [23:0] w);
        for (int b = 23; b >= 0; b--)
            if (w[b]) send_bit(38, 22); else send_bit(19, 41);
    endtask

    task automatic gap(input int n);
        bus.din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_pix(input logic [23:0] w, input logic [7:0] i);
        pix_t e;
        e.w = w;
        e.i = i;
        pix_q.push_back(e);
    endtask

    task automatic exp_frm(input logic [7:0] c, input logic e);
        frm_t x;
        x.cnt = c;
        x.err = e;
        frm_q.push_back(x);
    endtask

    task automatic chk_outputs_zero();
        chk("rst pixel", 32'(bus.pixel), 0);
        chk("rst pixel_valid", 32'(bus.pixel_valid), 0);
        chk("rst pixel_idx", 32'(bus.pixel_idx), 0);
        chk("rst frame_done", 32'(bus.frame_done), 0);
        chk("rst pixel_count", 32'(bus.pixel_count), 0);
        chk("rst bit_error", 32'(bus.bit_error), 0);
        chk("rst overflow", 32'(bus.overflow), 0);
    endtask

    // Scoreboard: pop and compare whenever the DUT strobes
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.pixel_valid) begin
                if (pix_q.size() == 0) begin
                    chk("unexpected pixel_valid", 32'(bus.pixel_valid), 0);
                end else begin
                    p = pix_q.pop_front();
                    chk("pixel", 32'(bus.pixel), 32'(p.w));
                    chk("pixel_idx", 32'(bus.pixel_idx), 32'(p.i));
                    chk("pixel latency", 32'(cyc - last_fall), 4);
                end
            end
            if (bus.frame_done) begin
                frames_seen++;
                if (frm_q.size() == 0) begin
                    chk("unexpected frame_done", 32'(bus.frame_done), 0);
                end else begin
                    f = frm_q.pop_front();
                    chk("pixel_count", 32'(bus.pixel_count), 32'(f.cnt));
                    chk("frame bit_error", 32'(bus.bit_error), 32'(f.err));
                    chk("frame latency", 32'(cyc - last_fall), 2402);
                end
            end
            if (bus.bit_error) err_events++;
        end
    end

    initial begin
        bus.din = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero();
        rst_n = 1'b1;
        gap(2410);

        // Basic frame of three pixels, then a second empty gap
        exp_pix(24'hFF0000, 8'd0); std_pixel(24'hFF0000);
        exp_pix(24'h00FF00, 8'd1); std_pixel(24'h00FF00);
        exp_pix(24'h0000A5, 8'd2); std_pixel(24'h0000A5);
        exp_frm(8'd3, 1'b0);
        gap(2410);
        chk("basic pixels drained", 32'(pix_q.size()), 0);
        chk("basic frame drained", 32'(frm_q.size()), 0);
        chk("basic frames", 32'(frames_seen), 1);
        chk("basic no error", 32'(err_events), 0);
        gap(2500);
        chk("double gap single frame", 32'(frames_seen), 1);

        // Threshold edges: 28,29,5,60 -> 0,1,0,1
        exp_pix(24'h555555, 8'd0);
        for (int k = 0; k < 6; k++) begin
            send_bit(28, 10); send_bit(29, 10); send_bit(5, 10); send_bit(60, 10);
        end
        gap(10);
        chk("threshold pixel drained", 32'(pix_q.size()), 0);
        send_bit(4, 10);
        chk("glitch error", 32'(err_events), 1);
        std_pixel(24'h123456);
        chk("no decode while resyncing", 32'(pix_q.size()), 0);
        gap(2500);
        exp_pix(24'h00C3F0, 8'd0); std_pixel(24'h00C3F0);
        send_bit(61, 10);
        chk("long high error", 32'(err_events), 2);
        gap(2500);
        exp_pix(24'hA5A5A5, 8'd0); std_pixel(24'hA5A5A5);
        exp_frm(8'd1, 1'b0);
        gap(2410);
        chk("threshold frames", 32'(frames_seen), 2);
        chk("threshold pixels drained", 32'(pix_q.size()), 0);

        // Partial pixel at latch: frame_done with bit_error, count 0
        for (int k = 0; k < 10; k++) send_bit(38, 10);
        exp_frm(8'd0, 1'b1);
        gap(2410);
        chk("partial frames", 32'(frames_seen), 3);
        chk("partial error", 32'(err_events), 3);
        exp_pix(24'h0F0F0F, 8'd0); std_pixel(24'h0F0F0F);
        exp_frm(8'd1, 1'b0);
        gap(2410);
        chk("after partial frames", 32'(frames_seen), 4);

        // 146 pixels: last two dropped with overflow
        for (int n = 0; n < 146; n++) begin
            if (n < 144) exp_pix(24'(n * 3), 8'(n));
            send_pixel(24'(n * 3), 30, 6, 2);
        end
        gap(10);
        chk("overflow set", 32'(bus.overflow), 1);
        chk("overflow pixels drained", 32'(pix_q.size()), 0);
        exp_frm(8'd144, 1'b0);
        gap(2410);
        chk("overflow cleared", 32'(bus.overflow), 0);
        chk("overflow frames", 32'(frames_seen), 5);
        chk("overflow no error", 32'(err_events), 3);

        // Reset mid-frame at bit 12 of pixel 5
        for (int n = 0; n < 5; n++) begin
            exp_pix(24'h100000 + 24'(n), 8'(n));
            std_pixel(24'h100000 + 24'(n));
        end
        for (int k = 0; k < 12; k++) send_bit(38, 22);
        bus.din = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero();
        chk("pre-reset pixels drained", 32'(pix_q.size()), 0);
        @(negedge clk);
        rst_n = 1'b1;
        std_pixel(24'h777777);
        gap(10);
        chk("ignored after reset", 32'(pix_q.size()), 0);
        gap(2500);
        exp_pix(24'hC0FFEE, 8'd0); std_pixel(24'hC0FFEE);
        exp_frm(8'd1, 1'b0);
        gap(2410);
        chk("post-reset frames", 32'(frames_seen), 6);
        chk("final pixels drained", 32'(pix_q.size()), 0);
        chk("final frames drained", 32'(frm_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
